// File: rtl/hazard_sequencer.sv
// ============================================================================
// Module   : hazard_sequencer
// Purpose  : Load-use stall, bubble, flush and EX forwarding control for the
//            six-stage IF/ID/EX/MEM1/MEM2/WB pipeline.
// Option   : HAZARD_PERF_CNT_EN adds the StallCnt/FlushCnt performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sequencer #(
  parameter int RA_W   = 5,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ValidD,
  input  logic [RA_W-1:0] Rs1D,
  input  logic [RA_W-1:0] Rs2D,
  input  logic [RA_W-1:0] RdD,
  input  logic            RegWriteD,
  input  logic            LoadD,
  input  logic            PCSrcE,
  output logic            StallF,
  output logic            StallD,
  output logic            SS2,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt
`endif
);

  if (RA_W < 1 || PERF_W < 1) begin : g_param_check
    $error("hazard_sequencer: RA_W and PERF_W must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LU2  = 2'd1,
    S_LU1  = 2'd2
  } stall_st_t;

  stall_st_t state_q, state_d;

  logic            e_v_q,  e_rw_q,  e_ld_q;
  logic [RA_W-1:0] e_rd_q, e_rs1_q, e_rs2_q;
  logic            e_v_d,  e_rw_d,  e_ld_d;
  logic [RA_W-1:0] e_rd_d, e_rs1_d, e_rs2_d;
  logic            m1_v_q, m1_rw_q, m1_ld_q;
  logic [RA_W-1:0] m1_rd_q;
  logic            m2_v_q, m2_rw_q, m2_ld_q;
  logic [RA_W-1:0] m2_rd_q;
  logic            w_v_q,  w_rw_q,  w_ld_q;
  logic [RA_W-1:0] w_rd_q;

  logic w_lu_e, w_lu_m1, w_stall, w_flush;

  function automatic logic prod_match(input logic v, input logic rw,
                                      input logic [RA_W-1:0] rd,
                                      input logic [RA_W-1:0] rs);
    return v & rw & (rd == rs) & (rs != '0);
  endfunction

  // A load in M1 must not forward its address; the stall keeps consumers out of EX.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (e_v_q && rs != '0) begin
      if (prod_match(m1_v_q, m1_rw_q, m1_rd_q, rs))      sel = m1_ld_q ? 2'b00 : 2'b10;
      else if (prod_match(m2_v_q, m2_rw_q, m2_rd_q, rs)) sel = 2'b11;
      else if (prod_match(w_v_q, w_rw_q, w_rd_q, rs))    sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_lu_e  = ValidD & e_ld_q &
                   (prod_match(e_v_q, e_rw_q, e_rd_q, Rs1D) | prod_match(e_v_q, e_rw_q, e_rd_q, Rs2D));
  assign w_lu_m1 = ValidD & m1_ld_q &
                   (prod_match(m1_v_q, m1_rw_q, m1_rd_q, Rs1D) | prod_match(m1_v_q, m1_rw_q, m1_rd_q, Rs2D));

  // Redirect wins over stall; everything reads idle while reset is held.
  assign w_flush = reset_n & PCSrcE;
  assign w_stall = reset_n & ~PCSrcE & (w_lu_e | w_lu_m1);

  assign StallF    = w_stall;
  assign StallD    = w_stall;
  assign SS2       = w_stall;
  assign FlushD    = w_flush;
  assign FlushE    = w_flush;
  assign ForwardAE = fwd_sel(e_rs1_q);
  assign ForwardBE = fwd_sel(e_rs2_q);

  always_comb begin
    e_v_d   = ValidD;
    e_rw_d  = RegWriteD;
    e_ld_d  = LoadD;
    e_rd_d  = RdD;
    e_rs1_d = Rs1D;
    e_rs2_d = Rs2D;
    if (w_stall || w_flush) begin
      e_v_d   = 1'b0;
      e_rw_d  = 1'b0;
      e_ld_d  = 1'b0;
      e_rd_d  = '0;
      e_rs1_d = '0;
      e_rs2_d = '0;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_LU2:   state_d = w_stall ? S_LU1 : S_IDLE;
      default: if (w_stall) state_d = w_lu_e ? S_LU2 : S_LU1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      e_v_q   <= 1'b0;  e_rw_q  <= 1'b0;  e_ld_q  <= 1'b0;
      e_rd_q  <= '0;    e_rs1_q <= '0;    e_rs2_q <= '0;
      m1_v_q  <= 1'b0;  m1_rw_q <= 1'b0;  m1_ld_q <= 1'b0;  m1_rd_q <= '0;
      m2_v_q  <= 1'b0;  m2_rw_q <= 1'b0;  m2_ld_q <= 1'b0;  m2_rd_q <= '0;
      w_v_q   <= 1'b0;  w_rw_q  <= 1'b0;  w_ld_q  <= 1'b0;  w_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      e_v_q   <= e_v_d;   e_rw_q  <= e_rw_d;  e_ld_q  <= e_ld_d;
      e_rd_q  <= e_rd_d;  e_rs1_q <= e_rs1_d; e_rs2_q <= e_rs2_d;
      m1_v_q  <= e_v_q;   m1_rw_q <= e_rw_q;  m1_ld_q <= e_ld_q;  m1_rd_q <= e_rd_q;
      m2_v_q  <= m1_v_q;  m2_rw_q <= m1_rw_q; m2_ld_q <= m1_ld_q; m2_rd_q <= m1_rd_q;
      w_v_q   <= m2_v_q;  w_rw_q  <= m2_rw_q; w_ld_q  <= m2_ld_q; w_rd_q  <= m2_rd_q;
    end
  end

  // The first stall cycle of an EX-stage load is always followed by an M1-stage one.
  a_lu2_then_lu1 : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == S_LU2 && !PCSrcE) |-> w_lu_m1);

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(w_stall);
      flush_cnt_q <= flush_cnt_q + PERF_W'(PCSrcE);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
// ============================================================================
// Module   : tb_hazard_sequencer
// Purpose  : Directed scoreboard bench for hazard_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_sequencer;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PW = 4;
`else
  localparam int PW = 32;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ValidD = 1'b0, RegWriteD = 1'b0, LoadD = 1'b0, PCSrcE = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic       StallF, StallD, SS2, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0] StallCnt, FlushCnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;
  int exp_fc = 0;
  logic [8:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  hazard_sequencer #(.RA_W(5), .PERF_W(PW)) dut (
    .clk(clk), .reset_n(rst_n), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .SS2(SS2), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  // Monitor: one expected output word per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {StallF, StallD, SS2, FlushD, FlushE, ForwardAE, ForwardBE};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got {stF,stD,ss2,flD,flE,fa,fb}=%b expected %b", nm, a, e);
      end
    end
  end

  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic rw, input logic ld, input logic pc,
                      input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input string nm);
    logic fl;
    ValidD = v; Rs1D = r1; Rs2D = r2; RdD = rd; RegWriteD = rw; LoadD = ld; PCSrcE = pc;
    fl = pc & rst_n;
    exp_q.push_back({st, st, st, fl, fl, fa, fb});
    name_q.push_back(nm);
    if (rst_n) begin
      if (st) exp_sc++;
      if (pc) exp_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, nm);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 0, 2'b00, 2'b00, "reset_hold");
    rst_n = 1'b1;
    idle(2, "reset_release");

    // ALU back-to-back: add x5; sub x6,x5,x3; x9 <- x5; x10 <- x6,x5
    step(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, "alu_issue");
    step(1, 5'd5, 5'd3, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00, "alu_c2");
    step(1, 5'd5, 5'd0, 5'd9, 1, 0, 0, 0, 2'b10, 2'b00, "alu_fwd_m1");
    step(1, 5'd6, 5'd5, 5'd10, 1, 0, 0, 0, 2'b11, 2'b00, "alu_fwd_m2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, "alu_fwd_m2_w");
    idle(4, "alu_drain");

    // Load-use distance 1: lw x7; add x8,x7,x7
    step(1, 5'd2, 5'd0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00, "lu1_load");
    step(1, 5'd7, 5'd7, 5'd8, 1, 0, 0, 1, 2'b00, 2'b00, "lu1_stall_a");
    step(1, 5'd7, 5'd7, 5'd8, 1, 0, 0, 1, 2'b00, 2'b00, "lu1_stall_b");
    step(1, 5'd7, 5'd7, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, "lu1_release");
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, "lu1_fwd_w");
    idle(4, "lu1_drain");

    // Load-use distance 2: lw x7; independent; add x12,x4,x7
    step(1, 5'd3, 5'd0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00, "lu2_load");
    step(1, 5'd1, 5'd2, 5'd11, 1, 0, 0, 0, 2'b00, 2'b00, "lu2_indep");
    step(1, 5'd4, 5'd7, 5'd12, 1, 0, 0, 1, 2'b00, 2'b00, "lu2_stall");
    step(1, 5'd4, 5'd7, 5'd12, 1, 0, 0, 0, 2'b00, 2'b00, "lu2_release");
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, "lu2_fwd_w");
    idle(4, "lu2_drain");

    // Flush beats stall; E must be a bubble afterwards (else fb would be 11)
    step(1, 5'd1, 5'd0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, "fl_add");
    step(1, 5'd2, 5'd0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00, "fl_load");
    step(1, 5'd7, 5'd9, 5'd13, 1, 0, 1, 0, 2'b00, 2'b00, "fl_priority");
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "fl_bubble");
    idle(4, "fl_drain");

    // x0 producers never stall or forward
    step(1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00, "x0_alu");
    step(1, 5'd0, 5'd0, 5'd14, 1, 0, 0, 0, 2'b00, 2'b00, "x0_cons");
    step(1, 5'd2, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, "x0_load");
    step(1, 5'd0, 5'd0, 5'd15, 1, 0, 0, 0, 2'b00, 2'b00, "x0_ld_cons");
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "x0_fwd");
    idle(4, "x0_drain");

    // Reset asserted during a stall clears the shadow immediately
    step(1, 5'd2, 5'd0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00, "rs_load");
    step(1, 5'd7, 5'd7, 5'd8, 1, 0, 0, 1, 2'b00, 2'b00, "rs_stall");
    rst_n = 1'b0;
    step(1, 5'd7, 5'd7, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, "rs_in_reset");
    rst_n = 1'b1;
    step(1, 5'd7, 5'd7, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, "rs_after");
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "rs_no_fwd");
    idle(3, "rs_drain");

    // 17 flushes in a row
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, "flush_burst");
    idle(1, "end_idle");

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
      end
    end

`ifdef HAZARD_PERF_CNT_EN
    begin
      logic [PW-1:0] es, ef;
      es = PW'(exp_sc);
      ef = PW'(exp_fc);
      checks++;
      if (StallCnt !== es) begin
        errors++;
        $display("FAIL stall_cnt: got %0d expected %0d", StallCnt, es);
      end
      checks++;
      if (FlushCnt !== ef) begin
        errors++;
        $display("FAIL flush_cnt_wrap: got %0d expected %0d", FlushCnt, ef);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
